// File: rtl/otter_pkg.sv
// Shared types and constants for the OTTER multicycle control unit.
package otter_pkg;

    typedef enum logic [6:0] {
        OpLoad   = 7'b0000011,
        OpStore  = 7'b0100011,
        OpBranch = 7'b1100011,
        OpJal    = 7'b1101111,
        OpJalr   = 7'b1100111,
        OpLui    = 7'b0110111,
        OpAuipc  = 7'b0010111,
        OpImm    = 7'b0010011,
        OpReg    = 7'b0110011,
        OpSystem = 7'b1110011
    } opcode_t;

    typedef enum logic [2:0] {
        ImmI = 3'd0,
        ImmS = 3'd1,
        ImmB = 3'd2,
        ImmU = 3'd3,
        ImmJ = 3'd4
    } imm_sel_t;

    typedef enum logic [2:0] {
        PcPlus4  = 3'd0,
        PcJalr   = 3'd1,
        PcBranch = 3'd2,
        PcJal    = 3'd3,
        PcMtvec  = 3'd4,
        PcMepc   = 3'd5
    } pc_sel_t;

    typedef enum logic [1:0] {
        StFetch     = 2'd0,
        StExec      = 2'd1,
        StWriteback = 2'd2,
        StInterrupt = 2'd3
    } cu_state_t;

    localparam logic [11:0] MRET_FUNC12 = 12'h302;
    localparam logic [2:0]  Func3Csrrw  = 3'b001;
    localparam logic [2:0]  Func3Priv   = 3'b000;

endpackage

// File: rtl/otter_br_cond_gen.sv
// Branch condition evaluation from func3 and the datapath comparator flags.
module otter_br_cond_gen (
    input  logic [2:0] func3_i,
    input  logic       br_eq_i,
    input  logic       br_lt_i,
    input  logic       br_ltu_i,
    output logic       taken_o,
    output logic       bad_func3_o
);

    // Decode func3 into a taken decision; 010/011 are not valid branch encodings.
    always_comb begin
        taken_o     = 1'b0;
        bad_func3_o = 1'b0;
        case (func3_i)
            3'b000:  taken_o = br_eq_i;
            3'b001:  taken_o = ~br_eq_i;
            3'b100:  taken_o = br_lt_i;
            3'b101:  taken_o = ~br_lt_i;
            3'b110:  taken_o = br_ltu_i;
            3'b111:  taken_o = ~br_ltu_i;
            default: bad_func3_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/otter_cu_fsm.sv
// OTTER multicycle control unit: FETCH/EXEC/WRITEBACK/INTERRUPT sequencing and decode.
module otter_cu_fsm
    import otter_pkg::*;
#(
    parameter bit ISR_EN     = 1'b1,
    parameter bit ILL_AS_NOP = 1'b1
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [31:0] ir,
    input  logic        br_eq,
    input  logic        br_lt,
    input  logic        br_ltu,
    input  logic        intr,
    input  logic        mie,
    output logic        pc_write,
    output logic        reg_write,
    output logic        mem_rden1,
    output logic        mem_rden2,
    output logic        mem_we2,
    output logic        csr_we,
    output logic        int_taken,
    output logic        mret_exec,
    output logic        illegal,
    output logic [2:0]  imm_sel,
    output logic [2:0]  pc_sel,
    output logic [1:0]  state_o
);

    cu_state_t state_q, state_d;
    cu_state_t retire_next;
    imm_sel_t  imm_sel_c;
    pc_sel_t   pc_sel_c;
    logic      br_taken, br_bad;
    logic      ill_c;
    logic      unused_ir;

    assign unused_ir = ^{ir[19:15], ir[11:7]};

    otter_br_cond_gen u_br_cond_gen (
        .func3_i     (ir[14:12]),
        .br_eq_i     (br_eq),
        .br_lt_i     (br_lt),
        .br_ltu_i    (br_ltu),
        .taken_o     (br_taken),
        .bad_func3_o (br_bad)
    );

    // Where a retiring instruction goes next: trap entry if enabled and pending.
    assign retire_next = (ISR_EN && intr && mie) ? StInterrupt : StFetch;

    // Decode strobes and next state from the registered state and the instruction.
    always_comb begin
        state_d   = state_q;
        pc_write  = 1'b0;
        reg_write = 1'b0;
        mem_rden1 = 1'b0;
        mem_rden2 = 1'b0;
        mem_we2   = 1'b0;
        csr_we    = 1'b0;
        int_taken = 1'b0;
        mret_exec = 1'b0;
        illegal   = 1'b0;
        ill_c     = 1'b0;
        imm_sel_c = ImmI;
        pc_sel_c  = PcPlus4;

        unique case (state_q)
            StFetch: begin
                mem_rden1 = 1'b1;
                state_d   = StExec;
            end
            StExec: begin
                state_d = retire_next;
                case (opcode_t'(ir[6:0]))
                    OpLoad: begin
                        imm_sel_c = ImmI;
                        mem_rden2 = 1'b1;
                        state_d   = StWriteback;
                    end
                    OpStore: begin
                        imm_sel_c = ImmS;
                        mem_we2   = 1'b1;
                        pc_write  = 1'b1;
                    end
                    OpBranch: begin
                        imm_sel_c = ImmB;
                        if (br_bad) begin
                            ill_c = 1'b1;
                        end else begin
                            pc_write = 1'b1;
                            pc_sel_c = br_taken ? PcBranch : PcPlus4;
                        end
                    end
                    OpJal: begin
                        imm_sel_c = ImmJ;
                        pc_sel_c  = PcJal;
                        reg_write = 1'b1;
                        pc_write  = 1'b1;
                    end
                    OpJalr: begin
                        imm_sel_c = ImmI;
                        pc_sel_c  = PcJalr;
                        reg_write = 1'b1;
                        pc_write  = 1'b1;
                    end
                    OpLui, OpAuipc: begin
                        imm_sel_c = ImmU;
                        reg_write = 1'b1;
                        pc_write  = 1'b1;
                    end
                    OpImm: begin
                        imm_sel_c = ImmI;
                        reg_write = 1'b1;
                        pc_write  = 1'b1;
                    end
                    OpReg: begin
                        reg_write = 1'b1;
                        pc_write  = 1'b1;
                    end
                    OpSystem: begin
                        if (ir[14:12] == Func3Csrrw) begin
                            csr_we    = 1'b1;
                            reg_write = 1'b1;
                            pc_write  = 1'b1;
                        end else if (ir[14:12] == Func3Priv && ir[31:20] == MRET_FUNC12) begin
                            mret_exec = 1'b1;
                            pc_sel_c  = PcMepc;
                            pc_write  = 1'b1;
                        end else begin
                            ill_c = 1'b1;
                        end
                    end
                    default: ill_c = 1'b1;
                endcase

                // Illegal encodings either retire as a NOP or park the FSM in EXEC.
                if (ill_c) begin
                    illegal = 1'b1;
                    if (ILL_AS_NOP) begin
                        pc_write = 1'b1;
                    end else begin
                        state_d = StExec;
                    end
                end
            end
            StWriteback: begin
                reg_write = 1'b1;
                pc_write  = 1'b1;
                pc_sel_c  = PcPlus4;
                state_d   = retire_next;
            end
            StInterrupt: begin
                int_taken = 1'b1;
                pc_sel_c  = PcMtvec;
                pc_write  = 1'b1;
                state_d   = StFetch;
            end
            default: state_d = StFetch;
        endcase

        imm_sel = imm_sel_c;
        pc_sel  = pc_sel_c;
        state_o = state_q;

        // Reset overrides everything so no partial write can escape mid-instruction.
        if (!RST_N) begin
            pc_write  = 1'b0;
            reg_write = 1'b0;
            mem_rden1 = 1'b0;
            mem_rden2 = 1'b0;
            mem_we2   = 1'b0;
            csr_we    = 1'b0;
            int_taken = 1'b0;
            mret_exec = 1'b0;
            illegal   = 1'b0;
            imm_sel   = 3'd0;
            pc_sel    = 3'd0;
            state_o   = 2'd0;
        end
    end

    // State register, cleared asynchronously to FETCH.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

endmodule
